// File: rtl/serial_pkg.sv
// serial_pkg: arbiter state encoding and length-width helper shared with the string sender.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        COMPLETE
    } arb_state_t;

    function automatic int len_w(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/serial_rr_select.sv
// serial_rr_select: picks the first active request at or after ptr_i, wrapping around.
module serial_rr_select #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    logic [IW-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/serial_str_arbiter.sv
// serial_str_arbiter: shares one string sender among N_REQ requesters.
// Define SERIAL_STR_ARB_RR_EN for round-robin; otherwise fixed priority, lowest index wins.
module serial_str_arbiter
    import serial_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int MAX_M_LEN = 32,
    localparam int LW = len_w(MAX_M_LEN),
    localparam int IW = $clog2(N_REQ),
    localparam int MW = MAX_M_LEN * 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*MW-1:0] req_message,
    input  logic [N_REQ*LW-1:0] req_len,
    output logic [N_REQ-1:0]    req_ack,
    output logic [N_REQ-1:0]    req_done,
    output logic                str_command,
    output logic [MW-1:0]       str_message,
    output logic [LW-1:0]       str_len,
    input  logic                str_busy,
    input  logic                str_done,
    output logic                busy,
    output logic [IW-1:0]       grant_id
);

    arb_state_t       state_q;
    logic [N_REQ-1:0] req_ack_q, req_done_q, win_gnt, owner_oh;
    logic             str_command_q;
    logic [MW-1:0]    str_message_q, msg_d;
    logic [LW-1:0]    str_len_q, len_raw, len_d;
    logic [IW-1:0]    grant_id_q, win_idx, ptr;

`ifdef SERIAL_STR_ARB_RR_EN
    logic [IW-1:0] ptr_q;
    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    serial_rr_select #(.N(N_REQ)) u_sel (
        .req_i(req_valid),
        .ptr_i(ptr),
        .gnt_o(win_gnt),
        .idx_o(win_idx)
    );

    assign msg_d    = req_message[int'(win_idx)*MW +: MW];
    assign len_raw  = req_len[int'(win_idx)*LW +: LW];
    assign len_d    = (len_raw > LW'(MAX_M_LEN)) ? LW'(MAX_M_LEN) : len_raw;
    assign owner_oh = N_REQ'(1) << grant_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            req_ack_q     <= '0;
            req_done_q    <= '0;
            str_command_q <= 1'b0;
            str_message_q <= '0;
            str_len_q     <= '0;
            grant_id_q    <= '0;
`ifdef SERIAL_STR_ARB_RR_EN
            ptr_q         <= '0;
`endif
        end else begin
            req_ack_q     <= '0;
            req_done_q    <= '0;
            str_command_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_valid && !str_busy) begin
                        grant_id_q    <= win_idx;
                        req_ack_q     <= win_gnt;
                        str_message_q <= msg_d;
                        str_len_q     <= len_d;
`ifdef SERIAL_STR_ARB_RR_EN
                        ptr_q         <= IW'((int'(win_idx) + 1) % N_REQ);
`endif
                        // Zero-length requests complete without touching the sender.
                        if (len_d == '0) begin
                            state_q    <= COMPLETE;
                            req_done_q <= win_gnt;
                        end else begin
                            state_q       <= ISSUE;
                            str_command_q <= 1'b1;
                        end
                    end
                end
                ISSUE: state_q <= WAIT_START;
                WAIT_START: begin
                    if (str_done) begin
                        state_q    <= COMPLETE;
                        req_done_q <= owner_oh;
                    end else if (str_busy) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (str_done) begin
                        state_q    <= COMPLETE;
                        req_done_q <= owner_oh;
                    end
                end
                COMPLETE: state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign req_ack     = req_ack_q;
    assign req_done    = req_done_q;
    assign str_command = str_command_q;
    assign str_message = str_message_q;
    assign str_len     = str_len_q;
    assign grant_id    = grant_id_q;
    assign busy        = state_q != IDLE;

endmodule

// File: doc/serial_str_arbiter.md
SERIAL_STR_ARBITER -- requirements
Module: serial_str_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter MAX_M_LEN, default 32, max message bytes, equal to the string sender's setting.
REQ-003 SHALL have clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have req_valid  input  N_REQ  per-requester send request, held until req_ack.
REQ-006 SHALL have req_message  input  N_REQ*MAX_M_LEN*8  per-requester message, byte 0 in LSBs, slice i for requester i.
REQ-007 SHALL have req_len  input  N_REQ*(clog2(MAX_M_LEN)+1)  per-requester byte count, slice i for requester i.
REQ-008 SHALL have req_ack  output  N_REQ  one-cycle pulse: request latched and committed.
REQ-009 SHALL have req_done  output  N_REQ  one-cycle pulse: committed message fully transmitted.
REQ-010 SHALL have str_command, str_message, str_len  outputs  1 / MAX_M_LEN*8 / clog2(MAX_M_LEN)+1  drive to string sender.
REQ-011 SHALL have str_busy, str_done  inputs  1 / 1  status from string sender.
REQ-012 SHALL have busy  output  1  high whenever not in IDLE.
REQ-013 SHALL have grant_id  output  clog2(N_REQ)  index of current owner, valid while busy.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_START, WAIT_DONE, COMPLETE.
REQ-015 IDLE: when any req_valid high and str_busy low, SHALL select a winner, register grant_id, latch its message/len, pulse req_ack[winner] next cycle, go ISSUE.
REQ-016 IDLE with str_busy high SHALL NOT grant; requests wait.
REQ-017 ISSUE: SHALL assert str_command for exactly one cycle with latched str_message/str_len stable, go WAIT_START.
REQ-018 str_message/str_len SHALL stay stable from ISSUE until COMPLETE.
REQ-019 WAIT_START: on str_busy high go WAIT_DONE; if str_done seen here, go COMPLETE directly.
REQ-020 WAIT_DONE: on str_done pulse go COMPLETE.
REQ-021 COMPLETE: SHALL pulse req_done[grant_id] one cycle, go IDLE; earliest next req_ack one cycle after COMPLETE.
REQ-022 Latency: req_valid seen in IDLE (cycle 0) -> req_ack and ISSUE in cycle 1 -> str_command high in cycle 1.
REQ-023 req_len greater than MAX_M_LEN SHALL be clamped to MAX_M_LEN when latched.
REQ-024 req_len = 0 SHALL be acked, then skip ISSUE/WAIT states and go COMPLETE; str_command never asserted.
REQ-025 req_valid dropped before ack SHALL be ignored; after ack, request is committed regardless of req_valid.
REQ-026 Requests arriving for the current owner during a transfer SHALL be treated as new requests after COMPLETE.
REQ-027 Only one bit of req_ack and req_done SHALL be high in any cycle.

Reset
REQ-028 rst SHALL force IDLE, req_ack=0, req_done=0, str_command=0, str_message=0, str_len=0, busy=0, grant_id=0, round-robin pointer=0.
REQ-029 rst mid-transfer SHALL abandon the transfer with no req_done; post-reset, REQ-016 guards a still-busy sender.

Configuration
REQ-030 With SERIAL_STR_ARB_RR_EN defined: round-robin; after serving i, priority starts at (i+1) mod N_REQ.
REQ-031 Without SERIAL_STR_ARB_RR_EN: fixed priority, lowest index wins, no pointer register.

Structure
REQ-032 Package serial_pkg SHALL hold the arbiter state enum and the length-width constant/function shared with the string sender.
REQ-033 Winner selection SHALL be one sub-module, serial_rr_select (request vector + pointer -> one-hot grant + index).

Verification
REQ-034 Single requester 1, len=3, msg bytes 0x41,0x42,0x43 -> req_ack[1] cycle 1, str_command one cycle, sender emits 41 42 43, req_done[1] once.
REQ-035 Requesters 0 and 2 valid simultaneously, RR_EN defined, three back-to-back rounds -> grant order 0,2,0; without RR_EN -> 0,0,0 while 0 stays valid.
REQ-036 req_len=0 on requester 3 -> req_ack[3], req_done[3] within 3 cycles, str_command never high.
REQ-037 req_len=40 with MAX_M_LEN=32 -> str_len=32, exactly 32 bytes sent.
REQ-038 rst pulsed while WAIT_DONE with str_busy held high 10 more cycles -> no req_done, no grant until str_busy low.
